// File: rtl/cpu_pkg.sv
// Shared fetch-side types and constants for the multicycle RV32 core.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_RSP     = 2'd1,
    S_OUT     = 2'd2,
    S_WAIT_PC = 2'd3
  } fetch_state_e;

  localparam logic [1:0] FETCH_OK       = 2'd0;
  localparam logic [1:0] FETCH_ACCESS   = 2'd1;
  localparam logic [1:0] FETCH_MISALIGN = 2'd2;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one memory read per architectural step, word held
// toward the decoder until accepted, then waits for write-back's next PC.
//
// state     | meaning
// S_REQ     | request pc from memory, hold until accepted
// S_RSP     | request accepted, waiting for read data
// S_OUT     | instruction (or fault) presented to decoder
// S_WAIT_PC | handed off, waiting for next PC from write-back
module ifu_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic [1:0]  ins_fault,
  input  logic        pc_wen,
  input  logic [31:0] pc_next,
  output logic [31:0] fetch_cnt
);

  fetch_state_e state;
  logic         rst_q;
  logic [31:0]  pc;
  logic [31:0]  buf_q;
  logic [31:0]  ins_pc_q;
  logic [1:0]   fault_q;
  logic [31:0]  cnt_q;

  // rst_q keeps the request low for every cycle in which reset was applied,
  // without creating a combinational path from rst to the port.
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      buf_q    <= '0;
      fault_q  <= FETCH_OK;
      ins_pc_q <= RESET_PC;
      cnt_q    <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (!rst_q && mem_req_ready) state <= S_RSP;
        end
        S_RSP: begin
          if (mem_rsp_valid) begin
            buf_q    <= mem_rsp_err ? 32'h0 : mem_rsp_data;
            fault_q  <= mem_rsp_err ? FETCH_ACCESS : FETCH_OK;
            ins_pc_q <= pc;
            state    <= S_OUT;
          end
        end
        S_OUT: begin
          if (ins_ready) begin
            cnt_q <= cnt_q + 32'd1;
            state <= S_WAIT_PC;
          end
        end
        S_WAIT_PC: begin
          if (pc_wen) begin
            pc <= pc_next;
            if (pc_next[1:0] != 2'b00) begin
              buf_q    <= '0;
              fault_q  <= FETCH_MISALIGN;
              ins_pc_q <= pc_next;
              state    <= S_OUT;
            end else begin
              state <= S_REQ;
            end
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  assign mem_req_valid = (state == S_REQ) && !rst_q;
  assign mem_req_addr  = pc;
  assign ins_valid     = (state == S_OUT);
  assign ins           = buf_q;
  assign ins_pc        = ins_pc_q;
  assign ins_fault     = fault_q;
  assign fetch_cnt     = cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: table of fetch vectors plus hand sequences.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic [1:0]  ins_fault;
  logic        pc_wen;
  logic [31:0] pc_next;
  logic [31:0] fetch_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins), .ins_pc(ins_pc),
    .ins_fault(ins_fault), .pc_wen(pc_wen), .pc_next(pc_next), .fetch_cnt(fetch_cnt)
  );

  typedef struct {
    logic [31:0] next_pc;
    logic [31:0] data;
    logic        err;
    logic [31:0] exp_ins;
    logic [1:0]  exp_fault;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // At a negedge in S_OUT: check presented word, handshake, check count.
  task automatic present(input logic [31:0] e_ins, input logic [1:0] e_fault, input logic [31:0] e_pc);
    chk("ins_valid", {31'b0, ins_valid}, 32'd1);
    chk("no_req_in_out", {31'b0, mem_req_valid}, 32'd0);
    chk("ins", ins, e_ins);
    chk("ins_fault", {30'b0, ins_fault}, {30'b0, e_fault});
    chk("ins_pc", ins_pc, e_pc);
    ins_ready = 1'b1;
    step();
    ins_ready = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    chk("ins_valid_drop", {31'b0, ins_valid}, 32'd0);
    chk("fetch_cnt", fetch_cnt, exp_cnt);
  endtask

  // At a negedge in S_REQ: accept immediately, respond next cycle, present.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input logic err,
                       input logic [31:0] e_ins, input logic [1:0] e_fault);
    chk("req_valid", {31'b0, mem_req_valid}, 32'd1);
    chk("req_addr", mem_req_addr, addr);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("req_drop", {31'b0, mem_req_valid}, 32'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = data;
    mem_rsp_err   = err;
    step();
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
    present(e_ins, e_fault, addr);
  endtask

  task automatic give_pc(input logic [31:0] p);
    pc_wen  = 1'b1;
    pc_next = p;
    step();
    pc_wen  = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h8000_0004, 32'h00a0_0113, 1'b0, 32'h00a0_0113, 2'd0};
    vecs[1] = '{32'h8000_0006, 32'h0,         1'b0, 32'h0,         2'd2};
    vecs[2] = '{32'h8000_0008, 32'hFFFF_FFFF, 1'b1, 32'h0,         2'd1};
    vecs[3] = '{32'h8000_000c, 32'hdead_beef, 1'b0, 32'hdead_beef, 2'd0};
    vecs[4] = '{32'h8000_0001, 32'h0,         1'b0, 32'h0,         2'd2};
    vecs[5] = '{32'h0000_1000, 32'h1234_5678, 1'b0, 32'h1234_5678, 2'd0};

    rst = 1'b1; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    mem_rsp_err = 1'b0; ins_ready = 1'b0; pc_wen = 1'b0; pc_next = '0;
    exp_cnt = '0;
    step(); step();
    chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_ins_valid", {31'b0, ins_valid}, 32'd0);
    chk("rst_ins", ins, 32'h0);
    chk("rst_ins_pc", ins_pc, 32'h8000_0000);
    chk("rst_fault", {30'b0, ins_fault}, 32'd0);
    chk("rst_cnt", fetch_cnt, 32'd0);

    rst = 1'b0;
    step();
    fetch(32'h8000_0000, 32'h0050_0093, 1'b0, 32'h0050_0093, 2'd0);

    for (int i = 0; i < 6; i++) begin
      give_pc(vecs[i].next_pc);
      if (vecs[i].next_pc[1:0] != 2'b00)
        present(vecs[i].exp_ins, vecs[i].exp_fault, vecs[i].next_pc);
      else
        fetch(vecs[i].next_pc, vecs[i].data, vecs[i].err, vecs[i].exp_ins, vecs[i].exp_fault);
    end

    // Backpressure on both sides, with pc_wen attempts that must be ignored.
    give_pc(32'h8000_0010);
    for (int i = 0; i < 3; i++) begin
      chk("bp_req_valid", {31'b0, mem_req_valid}, 32'd1);
      chk("bp_req_addr", mem_req_addr, 32'h8000_0010);
      step();
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    pc_wen = 1'b1; pc_next = 32'h0000_0040;
    step();
    pc_wen = 1'b0;
    chk("rsp_pcwen_ignored", mem_req_addr, 32'h8000_0010);
    chk("rsp_wait_no_req", {31'b0, mem_req_valid}, 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0041_0193;
    step();
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pc_wen = 1'b1; pc_next = 32'h0000_0080;
      chk("bp_ins_valid", {31'b0, ins_valid}, 32'd1);
      chk("bp_ins", ins, 32'h0041_0193);
      chk("bp_ins_pc", ins_pc, 32'h8000_0010);
      chk("bp_cnt", fetch_cnt, exp_cnt);
      step();
    end
    pc_wen = 1'b0;
    chk("out_pcwen_ignored", mem_req_addr, 32'h8000_0010);
    present(32'h0041_0193, 2'd0, 32'h8000_0010);

    // Stray response in S_WAIT_PC must not touch the buffer.
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1111_1111;
    step();
    mem_rsp_valid = 1'b0;
    chk("stray_rsp_ins", ins, 32'h0041_0193);
    chk("stray_rsp_state", {31'b0, ins_valid | mem_req_valid}, 32'd0);

    // Reset while waiting for a response, with a response in the same cycle.
    give_pc(32'h8000_0020);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    rst = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h2222_2222;
    step();
    mem_rsp_valid = 1'b0;
    chk("mid_rst_ins_valid", {31'b0, ins_valid}, 32'd0);
    chk("mid_rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("mid_rst_ins", ins, 32'h0);
    chk("mid_rst_cnt", fetch_cnt, 32'd0);
    rst = 1'b0;
    exp_cnt = '0;
    step();
    mem_req_ready = 1'b1;
    chk("post_rst_addr", mem_req_addr, 32'h8000_0000);
    chk("post_rst_valid", {31'b0, mem_req_valid}, 32'd1);
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0013;
    step();
    mem_rsp_valid = 1'b0;

    // Counter wrap on the next handshake.
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    chk("wrap_preset", fetch_cnt, 32'hFFFF_FFFF);
    present(32'h0000_0013, 2'd0, 32'h8000_0000);
    chk("wrap_zero", fetch_cnt, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
